// File: rtl/flashprog_pkg.sv
// Shared constants for the flashprog command protocol: opcode nibbles, ctrl words,
// request op codes, master FSM states and the command-byte selection function.
package flashprog_pkg;

   localparam logic [3:0] OPC_ADDR0  = 4'h0;
   localparam logic [3:0] OPC_ADDR1  = 4'h1;
   localparam logic [3:0] OPC_ADDR2  = 4'h2;
   localparam logic [3:0] OPC_ADDR3  = 4'h3;
   localparam logic [3:0] OPC_ADDR4  = 4'h4;
   localparam logic [3:0] OPC_ADDR5  = 4'h5;
   localparam logic [3:0] OPC_DATA0  = 4'h6;
   localparam logic [3:0] OPC_DATA1  = 4'h7;
   localparam logic [3:0] OPC_CTRL   = 4'h8;
   localparam logic [3:0] OPC_GETDAT = 4'h9;
   localparam logic [3:0] OPC_GETRDY = 4'hA;

   localparam logic [3:0] CTRL_IDLE = 4'hF;
   localparam logic [3:0] CTRL_WR   = 4'h5;
   localparam logic [3:0] CTRL_RD   = 4'h3;

   typedef enum logic [1:0] {
      OP_WRITE = 2'd0,
      OP_READ  = 2'd1,
      OP_POLL  = 2'd2,
      OP_CTRL  = 2'd3
   } req_op_t;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD     = 3'd1,
      ST_SEND     = 3'd2,
      ST_STROBE   = 3'd3,
      ST_GAP      = 3'd4,
      ST_WAIT_RSP = 3'd5,
      ST_DONE     = 3'd6
   } state_t;

   function automatic logic [3:0] last_step(input req_op_t op);
      logic [3:0] n;
      n = 4'd0;
      case (op)
         OP_WRITE: n = 4'd9;
         OP_READ:  n = 4'd8;
         default:  n = 4'd0;
      endcase
      return n;
   endfunction

   function automatic logic [3:0] addr_nib(input logic [22:0] addr, input logic [3:0] step);
      logic [3:0] nib;
      nib = 4'h0;
      case (step)
         4'd0: nib = addr[3:0];
         4'd1: nib = addr[7:4];
         4'd2: nib = addr[11:8];
         4'd3: nib = addr[15:12];
         4'd4: nib = addr[19:16];
         4'd5: nib = {1'b0, addr[22:20]};
         default: nib = 4'h0;
      endcase
      return nib;
   endfunction

   function automatic logic [7:0] cmd_byte(input req_op_t op, input logic [3:0] step,
                                            input logic [22:0] addr, input logic [7:0] data,
                                            input logic [3:0] ctrl);
      logic [7:0] b;
      b = 8'h00;
      case (op)
         OP_WRITE: begin
            if (step < 4'd6)       b = {step, addr_nib(addr, step)};
            else if (step == 4'd6) b = {OPC_DATA0, data[3:0]};
            else if (step == 4'd7) b = {OPC_DATA1, data[7:4]};
            else if (step == 4'd8) b = {OPC_CTRL, CTRL_WR};
            else                   b = {OPC_CTRL, CTRL_IDLE};
         end
         OP_READ: begin
            if (step < 4'd6)       b = {step, addr_nib(addr, step)};
            else if (step == 4'd6) b = {OPC_CTRL, CTRL_RD};
            else if (step == 4'd7) b = {OPC_GETDAT, 4'h0};
            else                   b = {OPC_CTRL, CTRL_IDLE};
         end
         OP_POLL: b = {OPC_GETRDY, 4'h0};
         default: b = {OPC_CTRL, ctrl};
      endcase
      return b;
   endfunction

endpackage

// File: rtl/flash_rsp_timer.sv
// Reply timeout down-counter: clear loads LOAD, enable counts toward zero, expired at zero.
module flash_rsp_timer
   import flashprog_pkg::*;
#(
   parameter int              TO_W = 21,
   parameter logic [TO_W-1:0] LOAD = '0
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic expired
);

   logic [TO_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (clear)
         cnt <= LOAD;
      else if (en && (cnt != '0))
         cnt <= cnt - TO_W'(1);
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/flash_cmd_master.sv
// Command-byte initiator for the flashprog responder; optional address-nibble cache
// is enabled by defining FLASH_ADDR_CACHE_EN.
//
// state    | meaning
// IDLE     | req_ready high, waiting for a request
// LOAD     | request latched, step reset
// SEND     | waiting for tx_ready (or skipping a cached address nibble)
// STROBE   | tx_write pulse with the current command byte
// GAP      | one cycle for xmtbuf to drop ready
// WAIT_RSP | waiting for the reply byte or the timeout
// DONE     | rsp_valid pulse
module flash_cmd_master
   import flashprog_pkg::*;
#(
   parameter int RSP_TIMEOUT = 2000000,
   parameter int TO_W        = 21
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [22:0] req_addr,
   input  logic [7:0]  req_data,
   input  logic [3:0]  req_ctrl,
   output logic        rsp_valid,
   output logic [7:0]  rsp_data,
   output logic        rsp_err,
   output logic        tx_write,
   input  logic        tx_ready,
   output logic [7:0]  tx_data,
   output logic        rx_read,
   input  logic        rx_ready,
   input  logic [7:0]  rx_data
);

   state_t      state, state_nx;
   req_op_t     op_q;
   logic [22:0] addr_q;
   logic [7:0]  data_q;
   logic [3:0]  ctrl_q;
   logic [3:0]  step_q;
   logic [7:0]  reply_q;
   logic [7:0]  rsp_data_q;
   logic        rsp_err_q;
   logic        drain_q;
   logic [7:0]  cur_byte;
   logic        is_query, is_last, skip, take, to_hit, expired;

   assign cur_byte = cmd_byte(op_q, step_q, addr_q, data_q, ctrl_q);
   assign is_query = (cur_byte[7:4] == OPC_GETDAT) || (cur_byte[7:4] == OPC_GETRDY);
   assign is_last  = (step_q == last_step(op_q));
   // a byte already being drained is never mistaken for the reply
   assign take     = (state == ST_WAIT_RSP) && rx_ready && !drain_q;
   assign to_hit   = (state == ST_WAIT_RSP) && !take && expired;

   // loaded two short so DONE lands exactly RSP_TIMEOUT cycles after the query strobe
   flash_rsp_timer #(
      .TO_W (TO_W),
      .LOAD (TO_W'(RSP_TIMEOUT - 2))
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (state == ST_STROBE),
      .en      ((state == ST_GAP) || (state == ST_WAIT_RSP)),
      .expired (expired)
   );

`ifdef FLASH_ADDR_CACHE_EN
   logic [23:0] shadow_q;
   logic [5:0]  sh_valid_q;
   logic        addr_step;

   assign addr_step = ((op_q == OP_WRITE) || (op_q == OP_READ)) && (step_q < 4'd6);
   assign skip      = addr_step && sh_valid_q[step_q[2:0]] &&
                      (shadow_q[{step_q[2:0], 2'b00} +: 4] == cur_byte[3:0]);

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q   <= '0;
         sh_valid_q <= '0;
      end else if (to_hit) begin
         sh_valid_q <= '0;
      end else if ((state == ST_STROBE) && addr_step) begin
         shadow_q[{step_q[2:0], 2'b00} +: 4] <= cur_byte[3:0];
         sh_valid_q[step_q[2:0]]             <= 1'b1;
      end
   end
`else
   assign skip = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:     if (req_valid) state_nx = ST_LOAD;
         ST_LOAD:     state_nx = ST_SEND;
         ST_SEND:     if (!skip && tx_ready) state_nx = ST_STROBE;
         ST_STROBE:   state_nx = ST_GAP;
         ST_GAP: begin
            if (is_query)     state_nx = ST_WAIT_RSP;
            else if (is_last) state_nx = ST_DONE;
            else              state_nx = ST_SEND;
         end
         ST_WAIT_RSP: begin
            if (take)         state_nx = is_last ? ST_DONE : ST_SEND;
            else if (expired) state_nx = ST_DONE;
         end
         ST_DONE:     state_nx = ST_IDLE;
         default:     state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         op_q       <= OP_WRITE;
         addr_q     <= '0;
         data_q     <= '0;
         ctrl_q     <= '0;
         step_q     <= '0;
         reply_q    <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
         drain_q    <= 1'b0;
      end else begin
         state   <= state_nx;
         drain_q <= rx_ready && !rx_read && (state != ST_WAIT_RSP);
         if ((state == ST_IDLE) && req_valid) begin
            op_q   <= req_op_t'(req_op);
            addr_q <= req_addr;
            data_q <= req_data;
            ctrl_q <= req_ctrl;
         end
         if (state == ST_LOAD) begin
            step_q  <= '0;
            reply_q <= '0;
         end
         if (((state == ST_SEND) && skip) ||
             ((state == ST_GAP) && !is_query && !is_last) ||
             (take && !is_last))
            step_q <= step_q + 4'd1;
         if (take)
            reply_q <= rx_data;
         if ((state != ST_DONE) && (state_nx == ST_DONE)) begin
            rsp_data_q <= to_hit ? 8'h00 : (take ? rx_data : reply_q);
            rsp_err_q  <= to_hit;
         end
      end
   end

   assign req_ready = (state == ST_IDLE);
   assign tx_write  = (state == ST_STROBE);
   assign tx_data   = tx_write ? cur_byte : 8'h00;
   assign rx_read   = drain_q || take;
   assign rsp_valid = (state == ST_DONE);
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_flash_cmd_master.sv
// Bench for flash_cmd_master: directed scenarios plus random requests checked against a
// byte-list reference model (follows FLASH_ADDR_CACHE_EN when defined).
module tb_flash_cmd_master;

   localparam int TO = 1000;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready;
   logic [1:0]  req_op;
   logic [22:0] req_addr;
   logic [7:0]  req_data;
   logic [3:0]  req_ctrl;
   logic        rsp_valid, rsp_err;
   logic [7:0]  rsp_data;
   logic        tx_write, tx_ready;
   logic [7:0]  tx_data;
   logic        rx_read, rx_ready;
   logic [7:0]  rx_data;

   int cyc = 0;
   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] exp_q[$];

   flash_cmd_master #(.RSP_TIMEOUT(TO), .TO_W(21)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_data(req_data), .req_ctrl(req_ctrl),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .tx_write(tx_write), .tx_ready(tx_ready), .tx_data(tx_data),
      .rx_read(rx_read), .rx_ready(rx_ready), .rx_data(rx_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

`ifdef FLASH_ADDR_CACHE_EN
   logic [3:0] sh_nib[6];
   bit         sh_val[6];
`endif

   task automatic model_reset();
`ifdef FLASH_ADDR_CACHE_EN
      for (int n = 0; n < 6; n++) sh_val[n] = 1'b0;
`endif
   endtask

   task automatic build_exp(input int op, input logic [22:0] addr, input logic [7:0] data,
                            input logic [3:0] ctrl, input bit timeout);
      logic [22:0] sh;
      logic [3:0]  nib;
      exp_q.delete();
      if (op <= 1) begin
         for (int n = 0; n < 6; n++) begin
            sh  = addr >> (4 * n);
            nib = sh[3:0];
`ifdef FLASH_ADDR_CACHE_EN
            if (sh_val[n] && sh_nib[n] == nib) continue;
            sh_val[n] = 1'b1;
            sh_nib[n] = nib;
`endif
            exp_q.push_back(8'((n << 4) | int'(nib)));
         end
      end
      case (op)
         0: begin
            exp_q.push_back(8'h60 | {4'h0, data[3:0]});
            exp_q.push_back(8'h70 | {4'h0, data[7:4]});
            exp_q.push_back(8'h85);
            exp_q.push_back(8'h8F);
         end
         1: begin
            exp_q.push_back(8'h83);
            exp_q.push_back(8'h90);
            if (!timeout) exp_q.push_back(8'h8F);
         end
         2: exp_q.push_back(8'hA0);
         default: exp_q.push_back({4'h8, ctrl});
      endcase
      if (timeout) model_reset();
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, " req_ready"}, req_ready, 1);
      chk({tag, " tx_write"},  tx_write, 0);
      chk({tag, " tx_data"},   tx_data, 0);
      chk({tag, " rsp_valid"}, rsp_valid, 0);
      chk({tag, " rsp_err"},   rsp_err, 0);
      chk({tag, " rsp_data"},  rsp_data, 0);
      chk({tag, " rx_read"},   rx_read, 0);
   endtask

   // rdelay < 0: no reply. hold_after/rst_after: byte count that triggers a 100-cycle
   // tx_ready stall / a reset (0 = unused). Entered just after a negedge.
   task automatic do_req(input int op, input logic [22:0] addr, input logic [7:0] data,
                         input logic [3:0] ctrl, input int rdelay, input logic [7:0] rbyte,
                         input bit rand_gap, input int hold_after, input int rst_after,
                         input bit chk_lat, input string tag);
      logic [7:0] got[$];
      bit   query  = (op == 1) || (op == 2);
      bit   timeout = query && (rdelay < 0);
      int   acc = 0, q_cyc = 0, rsp_cyc = 0, n_rsp = 0, n_rd = 0, n_bad = 0;
      int   rx_cnt = -1, gap_req = 0, gap_left = 0, rst_st = 0, post = 0, budget = 4000;
      int   c_hold = 0, c_next = 0;
      bit   rd_prev = 1'b0;
      logic [7:0] r_data = 8'h00;
      logic       r_err = 1'b0;
      logic [7:0] exp_data;

      build_exp(op, addr, data, ctrl, timeout);
      exp_data = (query && !timeout) ? rbyte : 8'h00;

      @(posedge clk); #1;
      req_valid = 1'b1; req_op = 2'(op); req_addr = addr; req_data = data; req_ctrl = ctrl;
      @(negedge clk);
      chk({tag, " req_ready_idle"}, req_ready, 1);
      acc = cyc;
      @(posedge clk); #1;
      req_valid = 1'b0;

      while (budget > 0 && !(n_rsp > 0 && cyc > rsp_cyc + 2) && !(rst_st == 4 && post == 0)) begin
         if (rd_prev) rx_ready = 1'b0;
         if (rx_cnt == 0) begin rx_ready = 1'b1; rx_data = rbyte; end
         if (rx_cnt >= 0) rx_cnt--;
         if (gap_left > 0) begin gap_left--; if (gap_left == 0) tx_ready = 1'b1; end
         if (gap_req > 0) begin tx_ready = 1'b0; gap_left = gap_req; gap_req = 0; end
         if (rst_st == 1) begin rst = 1'b1; rst_st = 2; end
         else if (rst_st == 2) begin rst = 1'b0; rst_st = 3; end
         if (rst_st == 4) post--;
         @(negedge clk);
         if (rst_st == 3) begin
            chk_reset_outs({tag, " mid_rst"});
            model_reset();
            rst_st = 4;
            post = 20;
         end
         if (tx_write) begin
            got.push_back(tx_data);
            if (!tx_ready) n_bad++;
            if (tx_data == 8'h90 || tx_data == 8'hA0) begin
               q_cyc = cyc;
               if (rdelay >= 0) rx_cnt = rdelay + 1;
            end
            if (hold_after > 0 && got.size() == hold_after) begin gap_req = 100; c_hold = cyc; end
            else if (hold_after > 0 && got.size() == hold_after + 1) c_next = cyc;
            else if (rand_gap) gap_req = $urandom_range(0, 3);
            if (rst_after > 0 && got.size() == rst_after && rst_st == 0) rst_st = 1;
         end
         rd_prev = rx_read;
         if (rx_read) n_rd++;
         if (n_rsp > 0 && cyc == rsp_cyc + 1) chk({tag, " ready_after"}, req_ready, 1);
         if (rsp_valid) begin
            n_rsp++;
            rsp_cyc = cyc;
            r_data = rsp_data;
            r_err = rsp_err;
            chk({tag, " ready_in_done"}, req_ready, 0);
         end
         @(posedge clk); #1;
         budget--;
      end
      if (budget == 0) chk({tag, " budget"}, 0, 1);
      tx_ready = 1'b1;
      rx_ready = 1'b0;

      if (rst_after > 0) begin
         chk({tag, " nbytes"}, got.size(), rst_after);
         for (int i = 0; i < rst_after && i < got.size(); i++) chk({tag, " byte"}, got[i], exp_q[i]);
         chk({tag, " rsp_count"}, n_rsp, 0);
      end else begin
         chk({tag, " nbytes"}, got.size(), exp_q.size());
         for (int i = 0; i < got.size() && i < exp_q.size(); i++) chk({tag, " byte"}, got[i], exp_q[i]);
         chk({tag, " rsp_count"}, n_rsp, 1);
         chk({tag, " rsp_data"}, r_data, exp_data);
         chk({tag, " rsp_err"}, r_err, timeout);
         chk({tag, " rx_read"}, n_rd, (query && !timeout) ? 1 : 0);
         chk({tag, " tx_low_write"}, n_bad, 0);
         if (timeout) chk({tag, " to_latency"}, rsp_cyc - q_cyc, TO);
         if (chk_lat) chk({tag, " latency"}, rsp_cyc - acc, 5);
         if (hold_after > 0) chk({tag, " stall"}, (c_next - c_hold) >= 100, 1);
      end
   endtask

   initial begin
      logic [22:0] pool[3];
      int op;
      rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_addr = '0; req_data = '0; req_ctrl = '0;
      tx_ready = 1'b1; rx_ready = 1'b0; rx_data = 8'h00;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_outs("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);

      do_req(0, 23'h123456, 8'hA5, 4'h0, -1, 8'h00, 1'b0, 0, 0, 1'b0, "t1_write");
      do_req(1, 23'h123456, 8'h00, 4'h0, 3, 8'h3C, 1'b0, 0, 0, 1'b0, "t2_read");
      do_req(2, 23'h0, 8'h00, 4'h0, 500, 8'h01, 1'b0, 0, 0, 1'b0, "t3_poll");
      do_req(1, 23'h7ABCDE, 8'h00, 4'h0, -1, 8'h00, 1'b0, 0, 0, 1'b0, "t4_timeout");
      do_req(0, 23'h0F0F0F, 8'h5A, 4'h0, -1, 8'h00, 1'b0, 3, 0, 1'b0, "t5_stall");
      do_req(0, 23'h654321, 8'hC3, 4'h0, -1, 8'h00, 1'b0, 0, 3, 1'b0, "t6_rst");
      do_req(3, 23'h0, 8'h00, 4'hF, -1, 8'h00, 1'b0, 0, 0, 1'b1, "t6_ctrl");

      // unsolicited byte while idle
      @(posedge clk); #1;
      rx_ready = 1'b1; rx_data = 8'h55;
      @(negedge clk); chk("drain_early", rx_read, 0);
      @(posedge clk); #1;
      @(negedge clk); chk("drain_pulse", rx_read, 1);
      @(posedge clk); #1;
      rx_ready = 1'b0;
      @(negedge clk); chk("drain_once", rx_read, 0);
      chk("drain_idle", req_ready, 1);

      pool[0] = 23'($urandom); pool[1] = 23'($urandom); pool[2] = 23'($urandom);
      for (int i = 0; i < 25; i++) begin
         op = int'($urandom_range(0, 3));
         do_req(op, ($urandom_range(0, 3) == 0) ? 23'($urandom) : pool[$urandom_range(0, 2)],
                8'($urandom), 4'($urandom), int'($urandom_range(0, 20)), 8'($urandom),
                1'b1, 0, 0, 1'b0, "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
